// File: rtl/img_stream_src_pkg.sv
// ---------------------------------------------------------------------------
// img_stream_src_pkg
//   Shared definitions for the dehaze frame-to-stream transmitter:
//   - default geometry / width parameters
//   - FSM state enum
//   - counter-width helper (clog2 with a floor of one bit)
//   - pixel-pack helpers for slicing a {r,g,b} word, with r in the MSBs
// ---------------------------------------------------------------------------
package img_stream_src_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_IMG_WIDTH  = 320;
  localparam int DEF_IMG_HEIGHT = 240;
  localparam int DEF_HBLANK     = 4;
  localparam int DEF_ADDR_WIDTH = 17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LINE,
    ST_HBLANK,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Counter width able to hold 0..n-1. A one-bit floor keeps degenerate
  // geometries (IMG_WIDTH=1, HBLANK=0) from producing zero-width vectors.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Component positions inside a packed {r,g,b} word.
  localparam int PIX_B = 0;
  localparam int PIX_G = 1;
  localparam int PIX_R = 2;

  // LSB position of component idx in a word of dw-bit components.
  function automatic int pix_lsb(input int dw, input int idx);
    return idx * dw;
  endfunction

endpackage

// File: rtl/img_stream_out_pipe.sv
// ---------------------------------------------------------------------------
// img_stream_out_pipe
//   Two-stage alignment pipeline between the read strobe and the pixel stream.
//   Stage 1 delays the read strobe and marker flags by one cycle so they line
//   up with the synchronous-read memory data. Stage 2 registers the outgoing
//   valid/data/marker beat. Components and markers are forced to zero on any
//   cycle without a valid beat. flush empties both stages on the next edge.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             clear both stages (frame abort)
//   rd_en_in          memory read strobe issued this cycle
//   sof_in/eol_in/eof_in  markers belonging to the pixel being read
//   mem_rdata         {r,g,b} read data, valid one cycle after rd_en_in
//   valid_out, r_out, g_out, b_out, sof, eol, eof   registered stream beat
// ---------------------------------------------------------------------------
module img_stream_out_pipe
  import img_stream_src_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    rd_en_in,
  input  logic                    sof_in,
  input  logic                    eol_in,
  input  logic                    eof_in,
  input  logic [3*DATA_WIDTH-1:0] mem_rdata,
  output logic                    valid_out,
  output logic [DATA_WIDTH-1:0]   r_out,
  output logic [DATA_WIDTH-1:0]   g_out,
  output logic [DATA_WIDTH-1:0]   b_out,
  output logic                    sof,
  output logic                    eol,
  output logic                    eof
);

  localparam int R_LSB = pix_lsb(DATA_WIDTH, PIX_R);
  localparam int G_LSB = pix_lsb(DATA_WIDTH, PIX_G);
  localparam int B_LSB = pix_lsb(DATA_WIDTH, PIX_B);

  logic                  s1_vld_q, s1_vld_d;
  logic                  s1_sof_q, s1_sof_d;
  logic                  s1_eol_q, s1_eol_d;
  logic                  s1_eof_q, s1_eof_d;
  logic                  vld_q, vld_d;
  logic                  sof_q, sof_d;
  logic                  eol_q, eol_d;
  logic                  eof_q, eof_d;
  logic [DATA_WIDTH-1:0] r_q, r_d;
  logic [DATA_WIDTH-1:0] g_q, g_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;

  always_comb begin
    s1_vld_d = rd_en_in & ~flush;
    s1_sof_d = rd_en_in & sof_in & ~flush;
    s1_eol_d = rd_en_in & eol_in & ~flush;
    s1_eof_d = rd_en_in & eof_in & ~flush;

    vld_d = s1_vld_q & ~flush;
    sof_d = s1_vld_q & s1_sof_q & ~flush;
    eol_d = s1_vld_q & s1_eol_q & ~flush;
    eof_d = s1_vld_q & s1_eof_q & ~flush;

    // Hold the datapath at zero between beats rather than leaking stale data.
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (vld_d) begin
      r_d = mem_rdata[R_LSB +: DATA_WIDTH];
      g_d = mem_rdata[G_LSB +: DATA_WIDTH];
      b_d = mem_rdata[B_LSB +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_sof_q <= 1'b0;
      s1_eol_q <= 1'b0;
      s1_eof_q <= 1'b0;
      vld_q    <= 1'b0;
      sof_q    <= 1'b0;
      eol_q    <= 1'b0;
      eof_q    <= 1'b0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_sof_q <= s1_sof_d;
      s1_eol_q <= s1_eol_d;
      s1_eof_q <= s1_eof_d;
      vld_q    <= vld_d;
      sof_q    <= sof_d;
      eol_q    <= eol_d;
      eof_q    <= eof_d;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
    end
  end

  assign valid_out = vld_q;
  assign r_out     = r_q;
  assign g_out     = g_q;
  assign b_out     = b_q;
  assign sof       = sof_q;
  assign eol       = eol_q;
  assign eof       = eof_q;

endmodule

// File: rtl/img_stream_src.sv
// ---------------------------------------------------------------------------
// img_stream_src
//   Reads an RGB frame from a synchronous-read pixel memory in raster order
//   and emits it as a valid/r/g/b stream with sof/eol/eof markers and
//   programmable blanking between lines. No backpressure.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             pulse; starts a frame when idle (base_addr latched)
//   abort             pulse; terminates the current frame, no done
//   base_addr         frame base address
//   busy              high while a frame is in progress
//   done              one-cycle pulse on normal frame completion
//   mem_rd_en/mem_addr  read port to pixel memory
//   mem_rdata         {r,g,b} read data, one cycle after mem_rd_en
//   valid_out, r_out, g_out, b_out, sof, eol, eof   pixel stream
// ---------------------------------------------------------------------------
module img_stream_src
  import img_stream_src_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int HBLANK     = DEF_HBLANK,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_rd_en,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [3*DATA_WIDTH-1:0] mem_rdata,
  output logic                    valid_out,
  output logic [DATA_WIDTH-1:0]   r_out,
  output logic [DATA_WIDTH-1:0]   g_out,
  output logic [DATA_WIDTH-1:0]   b_out,
  output logic                    sof,
  output logic                    eol,
  output logic                    eof
);

  localparam int X_W     = cnt_w(IMG_WIDTH);
  localparam int Y_W     = cnt_w(IMG_HEIGHT);
  localparam int HB_W    = cnt_w(HBLANK + 1);
  localparam int HB_LAST = (HBLANK > 0) ? HBLANK - 1 : 0;

  localparam logic [X_W-1:0]  X_LAST    = X_W'(IMG_WIDTH - 1);
  localparam logic [Y_W-1:0]  Y_LAST    = Y_W'(IMG_HEIGHT - 1);
  localparam logic [HB_W-1:0] HB_LAST_V = HB_W'(HB_LAST);

  state_e                state_q, state_d;
  logic [X_W-1:0]        x_q, x_d;
  logic [Y_W-1:0]        y_q, y_d;
  logic [HB_W-1:0]       hb_q, hb_d;
  logic                  drain_q, drain_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  // Running pixel offset from the frame base; it equals y*IMG_WIDTH + x in
  // LINE and simply holds through blanking, so no multiplier is needed.
  logic [ADDR_WIDTH-1:0] off_q, off_d;

  logic line_px;
  logic sof_flag, eol_flag, eof_flag;
  logic flush;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    hb_d    = hb_q;
    drain_d = drain_q;
    base_d  = base_q;
    off_d   = off_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_LINE;
          base_d  = base_addr;
          x_d     = '0;
          y_d     = '0;
          off_d   = '0;
        end
      end
      ST_LINE: begin
        off_d = off_q + 1'b1;
        if (x_q == X_LAST) begin
          x_d = '0;
          if (y_q == Y_LAST) begin
            state_d = ST_DRAIN;
            drain_d = 1'b0;
          end else begin
            y_d = y_q + 1'b1;
            if (HBLANK == 0) begin
              state_d = ST_LINE;
            end else begin
              state_d = ST_HBLANK;
              hb_d    = '0;
            end
          end
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      ST_HBLANK: begin
        if (hb_q == HB_LAST_V) begin
          state_d = ST_LINE;
        end else begin
          hb_d = hb_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        // Two cycles let the last read reach valid_out before done.
        if (drain_q) begin
          state_d = ST_DONE;
        end else begin
          drain_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      hb_q    <= '0;
      drain_q <= 1'b0;
      base_q  <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hb_q    <= hb_d;
      drain_q <= drain_d;
      base_q  <= base_d;
      off_q   <= off_d;
    end
  end

  assign line_px  = (state_q == ST_LINE);
  assign sof_flag = line_px && (x_q == '0) && (y_q == '0);
  assign eol_flag = line_px && (x_q == X_LAST);
  assign eof_flag = eol_flag && (y_q == Y_LAST);

  assign mem_rd_en = line_px;
  assign mem_addr  = line_px ? (base_q + off_q) : '0;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign flush     = abort && busy;

  img_stream_out_pipe #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .rd_en_in  (line_px),
    .sof_in    (sof_flag),
    .eol_in    (eol_flag),
    .eof_in    (eof_flag),
    .mem_rdata (mem_rdata),
    .valid_out (valid_out),
    .r_out     (r_out),
    .g_out     (g_out),
    .b_out     (b_out),
    .sof       (sof),
    .eol       (eol),
    .eof       (eof)
  );

endmodule

// File: tb/tb_img_stream_src.sv
// ---------------------------------------------------------------------------
// tb_img_stream_src
//   Three instances with different geometries share one clock and one pixel
//   memory. For each frame the expected cycle-by-cycle behaviour is derived
//   from the frame geometry: read of pixel p at cycle 1 + p + (p/W)*HB, beat
//   two cycles later, done at 3 + (H-1)*(W+HB) + W, idle after an abort.
// ---------------------------------------------------------------------------
module tb_img_stream_src;

  localparam int DW    = 8;
  localparam int AW    = 17;
  localparam int NI    = 3;
  localparam int AMASK = (1 << AW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            start_i [NI];
  logic            abort_i [NI];
  logic [AW-1:0]   base_i  [NI];
  logic [3*DW-1:0] rdata_i [NI];
  logic            busy_o  [NI];
  logic            done_o  [NI];
  logic            rd_o    [NI];
  logic [AW-1:0]   addr_o  [NI];
  logic            vld_o   [NI];
  logic [DW-1:0]   r_o     [NI];
  logic [DW-1:0]   g_o     [NI];
  logic [DW-1:0]   b_o     [NI];
  logic            sof_o   [NI];
  logic            eol_o   [NI];
  logic            eof_o   [NI];

  logic [3*DW-1:0] mem [0:(1<<AW)-1];

  int cfg_w  [NI] = '{4, 4, 1};
  int cfg_h  [NI] = '{3, 3, 1};
  int cfg_hb [NI] = '{2, 0, 3};

  int n_cmp = 0;
  int n_bad = 0;

  img_stream_src #(.DATA_WIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(3), .HBLANK(2), .ADDR_WIDTH(AW)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_i[0]), .abort(abort_i[0]), .base_addr(base_i[0]),
    .busy(busy_o[0]), .done(done_o[0]), .mem_rd_en(rd_o[0]), .mem_addr(addr_o[0]), .mem_rdata(rdata_i[0]),
    .valid_out(vld_o[0]), .r_out(r_o[0]), .g_out(g_o[0]), .b_out(b_o[0]),
    .sof(sof_o[0]), .eol(eol_o[0]), .eof(eof_o[0]));

  img_stream_src #(.DATA_WIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(3), .HBLANK(0), .ADDR_WIDTH(AW)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_i[1]), .abort(abort_i[1]), .base_addr(base_i[1]),
    .busy(busy_o[1]), .done(done_o[1]), .mem_rd_en(rd_o[1]), .mem_addr(addr_o[1]), .mem_rdata(rdata_i[1]),
    .valid_out(vld_o[1]), .r_out(r_o[1]), .g_out(g_o[1]), .b_out(b_o[1]),
    .sof(sof_o[1]), .eol(eol_o[1]), .eof(eof_o[1]));

  img_stream_src #(.DATA_WIDTH(DW), .IMG_WIDTH(1), .IMG_HEIGHT(1), .HBLANK(3), .ADDR_WIDTH(AW)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_i[2]), .abort(abort_i[2]), .base_addr(base_i[2]),
    .busy(busy_o[2]), .done(done_o[2]), .mem_rd_en(rd_o[2]), .mem_addr(addr_o[2]), .mem_rdata(rdata_i[2]),
    .valid_out(vld_o[2]), .r_out(r_o[2]), .g_out(g_o[2]), .b_out(b_o[2]),
    .sof(sof_o[2]), .eol(eol_o[2]), .eof(eof_o[2]));

  // Synchronous-read pixel memory, one read port per instance.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rd_o[i]) rdata_i[i] <= mem[addr_o[i]];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ctrl_obs(input int k);
    return 64'({busy_o[k], done_o[k], rd_o[k], addr_o[k]});
  endfunction

  function automatic logic [63:0] strm_obs(input int k);
    return 64'({vld_o[k], sof_o[k], eol_o[k], eof_o[k], r_o[k], g_o[k], b_o[k]});
  endfunction

  // Runs one frame on instance k, checking every cycle. abort_c / extra_c are
  // cycles (relative to the start pulse) for an abort or a second start; -1
  // means none, and extra_c = -2 places the second start on the done cycle.
  task automatic run_frame(input int k, input int base, input int abort_c,
                           input int extra_c, input string name);
    int W, H, P, done_c, xc, beats;
    W = cfg_w[k];
    H = cfg_h[k];
    P = W + cfg_hb[k];
    done_c = 3 + (H - 1) * P + W;
    xc = (extra_c == -2) ? done_c : extra_c;
    beats = 0;
    @(negedge clk);
    for (int c = 0; c <= done_c + 3; c++) begin
      bit idle, e_rd, e_v;
      int e_addr, q, l, pos, p;
      logic [3*DW-1:0] w;
      logic [63:0] e_ctrl, e_strm;
      start_i[k] = (c == 0) || (c == xc);
      abort_i[k] = (c == abort_c);
      base_i[k]  = (c == 0) ? AW'(base) : AW'($urandom);
      idle = (c == 0) || (c > done_c) || (abort_c >= 0 && c > abort_c);
      e_rd = 1'b0; e_addr = 0;
      if (!idle && c >= 1) begin
        q = c - 1; l = q / P; pos = q % P;
        if (l < H && pos < W) begin
          e_rd = 1'b1;
          e_addr = (base + l * W + pos) & AMASK;
        end
      end
      e_strm = '0;
      e_v = 1'b0;
      if (!idle && c >= 3) begin
        q = c - 3; l = q / P; pos = q % P;
        if (l < H && pos < W) begin
          e_v = 1'b1;
          p = l * W + pos;
          w = mem[(base + p) & AMASK];
          e_strm = 64'({1'b1, (p == 0), (pos == W - 1), (p == W * H - 1), w});
        end
      end
      e_ctrl = 64'({!idle, (!idle && c == done_c), e_rd, AW'(e_addr)});
      #1;
      check($sformatf("%s/i%0d/c%0d/ctrl", name, k, c), ctrl_obs(k), e_ctrl);
      check($sformatf("%s/i%0d/c%0d/strm", name, k, c), strm_obs(k), e_strm);
      if (e_v) beats++;
      @(negedge clk);
    end
    start_i[k] = 1'b0;
    abort_i[k] = 1'b0;
    $display("frame %s inst=%0d base=%0d abort_c=%0d extra_c=%0d beats=%0d",
             name, k, base, abort_c, xc, beats);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      start_i[i] = 1'b0;
      abort_i[i] = 1'b0;
      base_i[i]  = '0;
    end
    for (int a = 0; a <= AMASK; a++) begin
      mem[a] = {DW'(a), DW'(a + 1), DW'(a + 2)};
    end

    // Reset state of all instances.
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("reset/i%0d/ctrl", k), ctrl_obs(k), 64'd0);
      check($sformatf("reset/i%0d/strm", k), strm_obs(k), 64'd0);
    end
    rst_n = 1'b1;

    // Directed frames with the address pattern memory.
    run_frame(0, 0, -1, -1, "basic");
    run_frame(1, (1 << AW) - 5, -1, -1, "wrap");
    run_frame(2, 0, -1, -1, "single");
    run_frame(0, 0, -1, 5, "dblstart");

    // Random memory contents from here on.
    for (int a = 0; a <= AMASK; a++) mem[a] = 24'($urandom);

    run_frame(0, int'($urandom_range(AMASK, 0)), 9, -1, "abort");
    run_frame(0, int'($urandom_range(AMASK, 0)), -1, -1, "postabort");
    run_frame(0, int'($urandom_range(AMASK, 0)), 0, -1, "startabort");
    run_frame(0, int'($urandom_range(AMASK, 0)), -1, -2, "startdone");

    // Asynchronous reset in the middle of a frame.
    @(negedge clk);
    start_i[0] = 1'b1;
    base_i[0]  = AW'($urandom);
    @(negedge clk);
    start_i[0] = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset/ctrl", ctrl_obs(0), 64'd0);
    check("midreset/strm", strm_obs(0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("postreset/c%0d/ctrl", c), ctrl_obs(0), 64'd0);
      check($sformatf("postreset/c%0d/strm", c), strm_obs(0), 64'd0);
    end
    $display("frame midreset inst=0 reset released, idle checked");

    // Randomised frames: random instance, base and optional abort point.
    for (int t = 0; t < 6; t++) begin
      int k, dc, ab;
      k  = int'($urandom_range(NI - 1, 0));
      dc = 3 + (cfg_h[k] - 1) * (cfg_w[k] + cfg_hb[k]) + cfg_w[k];
      ab = ($urandom_range(1, 0) == 0) ? -1 : int'($urandom_range(dc, 0));
      run_frame(k, int'($urandom_range(AMASK, 0)), ab, -1, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
